// File: rtl/mad_pkg.sv
// rtl/mad_pkg.sv - shared state encoding and defaults for the interrupt controller
package mad_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT_SAFE = 4'd1,
        ST_DRAIN     = 4'd2,
        ST_PUSH_PC   = 4'd3,
        ST_PUSH_FLG  = 4'd4,
        ST_FETCH_VEC = 4'd5,
        ST_ISR       = 4'd6,
        ST_POP_FLG   = 4'd7,
        ST_POP_PC    = 4'd8
    } state_t;

    localparam int          DRAIN_CYCLES_DEF = 3;
    localparam logic [10:0] VEC_ADDR_DEF     = 11'h001;
    localparam logic [10:0] SP_INIT_DEF      = 11'h7FF;
    localparam int          CNT_W            = 8;

    function automatic logic is_busy(state_t s);
        return !(s == ST_IDLE || s == ST_ISR);
    endfunction

endpackage

// File: rtl/mad_edge_detect.sv
// rtl/mad_edge_detect.sv - rising-edge detector for the external interrupt line
module mad_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_int,
    output logic o_event
);

    logic r_int_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_int_q <= 1'b0;
        end else begin
            r_int_q <= i_int;
        end
    end

    assign o_event = i_int & ~r_int_q;

endmodule

// File: rtl/mad_int_ctrl.sv
// rtl/mad_int_ctrl.sv - interrupt entry/exit sequencer: drain, stack push/pop, vector fetch
module mad_int_ctrl
    import mad_pkg::*;
#(
    parameter int          DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter logic [10:0] VEC_ADDR     = VEC_ADDR_DEF,
    parameter logic [10:0] SP_INIT      = SP_INIT_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_int,
    input  logic        i_safe,
    input  logic        i_rti,
    input  logic [15:0] i_pc_ret,
    input  logic [3:0]  i_flags,
    input  logic        i_mem_gnt,
    input  logic [15:0] i_mem_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [10:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    output logic        o_freeze,
    output logic        o_flush,
    output logic        o_pc_load,
    output logic [15:0] o_pc_value,
    output logic        o_flags_load,
    output logic [3:0]  o_flags_value,
    output logic        o_busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [10:0]        r_sp;
    logic [10:0]        w_sp_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pending;
    logic [15:0]        r_pc_cap;
    logic [3:0]         r_flg_cap;
    logic               w_event;
    logic               w_fire;
    logic               w_capture;
    logic               w_cnt_last;

    logic               w_mem_req_nxt;
    logic               w_mem_we_nxt;
    logic [10:0]        w_mem_addr_nxt;
    logic [15:0]        w_mem_wdata_nxt;
    logic               w_freeze_nxt;
    logic               w_flush_nxt;
    logic               w_pc_load_nxt;
    logic [15:0]        w_pc_value_nxt;
    logic               w_flags_load_nxt;
    logic [3:0]         w_flags_value_nxt;

    mad_edge_detect u_edge (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_int   (i_int),
        .o_event (w_event)
    );

    // A transfer completes only when our registered request meets the grant.
    assign w_fire     = o_mem_req & i_mem_gnt;
    assign w_capture  = (r_state == ST_WAIT_SAFE) & i_safe;
    assign w_cnt_last = (r_cnt == CNT_W'(DRAIN_CYCLES - 1));

    always_comb begin
        w_state_nxt       = r_state;
        w_sp_nxt          = r_sp;
        w_pc_load_nxt     = 1'b0;
        w_pc_value_nxt    = 16'h0000;
        w_flags_load_nxt  = 1'b0;
        w_flags_value_nxt = 4'h0;
        case (r_state)
            ST_IDLE:      if (r_pending | w_event) w_state_nxt = ST_WAIT_SAFE;
            ST_WAIT_SAFE: if (i_safe) w_state_nxt = ST_DRAIN;
            ST_DRAIN:     if (w_cnt_last) w_state_nxt = ST_PUSH_PC;
            ST_PUSH_PC: begin
                if (w_fire) begin
                    w_sp_nxt    = r_sp - 11'd1;
                    w_state_nxt = ST_PUSH_FLG;
                end
            end
            ST_PUSH_FLG: begin
                if (w_fire) begin
                    w_sp_nxt    = r_sp - 11'd1;
                    w_state_nxt = ST_FETCH_VEC;
                end
            end
            ST_FETCH_VEC: begin
                if (w_fire) begin
                    w_pc_load_nxt  = 1'b1;
                    w_pc_value_nxt = i_mem_rdata;
                    w_state_nxt    = ST_ISR;
                end
            end
            ST_ISR:       if (i_rti) w_state_nxt = ST_POP_FLG;
            ST_POP_FLG: begin
                if (w_fire) begin
                    w_sp_nxt          = r_sp + 11'd1;
                    w_flags_load_nxt  = 1'b1;
                    w_flags_value_nxt = i_mem_rdata[3:0];
                    w_state_nxt       = ST_POP_PC;
                end
            end
            ST_POP_PC: begin
                if (w_fire) begin
                    w_sp_nxt       = r_sp + 11'd1;
                    w_pc_load_nxt  = 1'b1;
                    w_pc_value_nxt = i_mem_rdata;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state register.
    always_comb begin
        w_mem_req_nxt   = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = 11'h000;
        w_mem_wdata_nxt = 16'h0000;
        w_freeze_nxt    = 1'b0;
        w_flush_nxt     = 1'b0;
        case (w_state_nxt)
            ST_WAIT_SAFE: w_freeze_nxt = 1'b1;
            ST_DRAIN: begin
                w_freeze_nxt = 1'b1;
                w_flush_nxt  = 1'b1;
            end
            ST_PUSH_PC: begin
                w_freeze_nxt    = 1'b1;
                w_mem_req_nxt   = 1'b1;
                w_mem_we_nxt    = 1'b1;
                w_mem_addr_nxt  = w_sp_nxt;
                w_mem_wdata_nxt = r_pc_cap;
            end
            ST_PUSH_FLG: begin
                w_freeze_nxt    = 1'b1;
                w_mem_req_nxt   = 1'b1;
                w_mem_we_nxt    = 1'b1;
                w_mem_addr_nxt  = w_sp_nxt;
                w_mem_wdata_nxt = {12'h000, r_flg_cap};
            end
            ST_FETCH_VEC: begin
                w_freeze_nxt   = 1'b1;
                w_mem_req_nxt  = 1'b1;
                w_mem_addr_nxt = VEC_ADDR;
            end
            ST_POP_FLG, ST_POP_PC: begin
                w_freeze_nxt   = 1'b1;
                w_mem_req_nxt  = 1'b1;
                w_mem_addr_nxt = w_sp_nxt + 11'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_sp          <= SP_INIT;
            r_cnt         <= '0;
            r_pending     <= 1'b0;
            r_pc_cap      <= 16'h0000;
            r_flg_cap     <= 4'h0;
            o_mem_req     <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_addr    <= 11'h000;
            o_mem_wdata   <= 16'h0000;
            o_freeze      <= 1'b0;
            o_flush       <= 1'b0;
            o_pc_load     <= 1'b0;
            o_pc_value    <= 16'h0000;
            o_flags_load  <= 1'b0;
            o_flags_value <= 4'h0;
            o_busy        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sp    <= w_sp_nxt;
            r_cnt   <= (r_state == ST_DRAIN && w_state_nxt == ST_DRAIN) ? r_cnt + 1'b1 : '0;
            // A fresh edge wins over the clear so it is not lost on DRAIN entry.
            if (w_event) begin
                r_pending <= 1'b1;
            end else if (w_capture) begin
                r_pending <= 1'b0;
            end
            if (w_capture) begin
                r_pc_cap  <= i_pc_ret;
                r_flg_cap <= i_flags;
            end
            o_mem_req     <= w_mem_req_nxt;
            o_mem_we      <= w_mem_we_nxt;
            o_mem_addr    <= w_mem_addr_nxt;
            o_mem_wdata   <= w_mem_wdata_nxt;
            o_freeze      <= w_freeze_nxt;
            o_flush       <= w_flush_nxt;
            o_pc_load     <= w_pc_load_nxt;
            o_pc_value    <= w_pc_value_nxt;
            o_flags_load  <= w_flags_load_nxt;
            o_flags_value <= w_flags_value_nxt;
            o_busy        <= is_busy(w_state_nxt);
        end
    end

endmodule

// File: tb/tb_mad_int_ctrl.sv
// tb/tb_mad_int_ctrl.sv - directed table and sequence checks for mad_int_ctrl
module tb_mad_int_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_int, safe, rti, gnt;
    logic [15:0] pc_ret, rdata;
    logic [3:0]  flags;

    logic        o_mem_req, o_mem_we, o_freeze, o_flush, o_pc_load, o_flags_load, o_busy;
    logic [10:0] o_mem_addr;
    logic [15:0] o_mem_wdata, o_pc_value;
    logic [3:0]  o_flags_value;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mad_int_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_int        (in_int),
        .i_safe       (safe),
        .i_rti        (rti),
        .i_pc_ret     (pc_ret),
        .i_flags      (flags),
        .i_mem_gnt    (gnt),
        .i_mem_rdata  (rdata),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_freeze     (o_freeze),
        .o_flush      (o_flush),
        .o_pc_load    (o_pc_load),
        .o_pc_value   (o_pc_value),
        .o_flags_load (o_flags_load),
        .o_flags_value(o_flags_value),
        .o_busy       (o_busy)
    );

    // {req, we, addr, wdata, freeze, flush, pc_load, pc_value, flags_load, flags_value, busy}
    logic [53:0] obs;
    assign obs = {o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_freeze, o_flush,
                  o_pc_load, o_pc_value, o_flags_load, o_flags_value, o_busy};

    function automatic logic [53:0] pk(logic req, logic we, logic [10:0] addr, logic [15:0] wd,
                                       logic frz, logic fl, logic pl, logic [15:0] pv,
                                       logic fll, logic [3:0] fv, logic busy);
        return {req, we, addr, wd, frz, fl, pl, pv, fll, fv, busy};
    endfunction

    typedef struct {
        logic        v_int;
        logic        v_safe;
        logic        v_rti;
        logic        v_gnt;
        logic [15:0] v_rdata;
        logic [53:0] v_exp;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_int = 0; safe = 0; rti = 0; gnt = 0;
        pc_ret = 16'h0020; flags = 4'hA; rdata = 16'h0000;

        //             int safe rti gnt rdata      req we addr    wdata     frz fl pl pv        fll fv  busy
        vecs[0]  = '{0, 0, 0, 0, 16'h0000, pk(0, 0, 11'h000, 16'h0000, 0, 0, 0, 16'h0000, 0, 4'h0, 0)};
        vecs[1]  = '{1, 1, 0, 1, 16'h0000, pk(0, 0, 11'h000, 16'h0000, 1, 0, 0, 16'h0000, 0, 4'h0, 1)};
        vecs[2]  = '{1, 1, 0, 1, 16'h0000, pk(0, 0, 11'h000, 16'h0000, 1, 1, 0, 16'h0000, 0, 4'h0, 1)};
        vecs[3]  = '{1, 1, 0, 1, 16'h0000, pk(0, 0, 11'h000, 16'h0000, 1, 1, 0, 16'h0000, 0, 4'h0, 1)};
        vecs[4]  = '{1, 1, 0, 1, 16'h0000, pk(0, 0, 11'h000, 16'h0000, 1, 1, 0, 16'h0000, 0, 4'h0, 1)};
        vecs[5]  = '{1, 1, 0, 1, 16'h0000, pk(1, 1, 11'h7FF, 16'h0020, 1, 0, 0, 16'h0000, 0, 4'h0, 1)};
        vecs[6]  = '{1, 1, 0, 1, 16'h0000, pk(1, 1, 11'h7FE, 16'h000A, 1, 0, 0, 16'h0000, 0, 4'h0, 1)};
        vecs[7]  = '{1, 1, 0, 1, 16'h0000, pk(1, 0, 11'h001, 16'h0000, 1, 0, 0, 16'h0000, 0, 4'h0, 1)};
        vecs[8]  = '{1, 1, 0, 1, 16'h0100, pk(0, 0, 11'h000, 16'h0000, 0, 0, 1, 16'h0100, 0, 4'h0, 0)};
        vecs[9]  = '{1, 1, 0, 1, 16'h0000, pk(0, 0, 11'h000, 16'h0000, 0, 0, 0, 16'h0000, 0, 4'h0, 0)};
        vecs[10] = '{1, 1, 1, 1, 16'h0000, pk(1, 0, 11'h7FE, 16'h0000, 1, 0, 0, 16'h0000, 0, 4'h0, 1)};
        vecs[11] = '{1, 1, 0, 1, 16'h000A, pk(1, 0, 11'h7FF, 16'h0000, 1, 0, 0, 16'h0000, 1, 4'hA, 1)};
        vecs[12] = '{1, 1, 0, 1, 16'h0020, pk(0, 0, 11'h000, 16'h0000, 0, 0, 1, 16'h0020, 0, 4'h0, 0)};
        vecs[13] = '{0, 1, 0, 1, 16'h0000, pk(0, 0, 11'h000, 16'h0000, 0, 0, 0, 16'h0000, 0, 4'h0, 0)};

        cyc(); cyc();
        chk("reset_outputs", 64'(obs), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            in_int = vecs[i].v_int; safe = vecs[i].v_safe; rti = vecs[i].v_rti;
            gnt = vecs[i].v_gnt; rdata = vecs[i].v_rdata;
            cyc();
            chk($sformatf("vec%0d", i), 64'(obs), 64'(vecs[i].v_exp));
        end

        // Safe held low: frozen, nothing flushed, no memory request
        pc_ret = 16'h1234; flags = 4'h5; gnt = 0; safe = 0; rti = 0;
        in_int = 1; cyc();
        chk("wait_entry", 64'({o_freeze, o_flush, o_mem_req, o_busy}), 64'(4'b1001));
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("wait_safe%0d", i), 64'({o_freeze, o_flush, o_mem_req}), 64'(3'b100));
        end
        safe = 1; cyc();
        chk("drain_entry", 64'({o_freeze, o_flush, o_mem_req}), 64'(3'b110));
        safe = 0; pc_ret = 16'hFFFF; flags = 4'hF;
        cyc(); cyc(); cyc();
        chk("push_pc_cap", 64'({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata}), 64'({2'b11, 11'h7FF, 16'h1234}));

        // Grant withheld in PUSH_PC
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("push_hold%0d", i), 64'({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata}),
                64'({2'b11, 11'h7FF, 16'h1234}));
        end
        gnt = 1; cyc();
        chk("push_flg", 64'({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata}), 64'({2'b11, 11'h7FE, 16'h0005}));
        cyc();
        chk("fetch_vec", 64'({o_mem_req, o_mem_we, o_mem_addr}), 64'({2'b10, 11'h001}));
        rdata = 16'h0200; cyc();
        chk("isr_pc_load", 64'({o_pc_load, o_pc_value, o_busy, o_freeze}), 64'({1'b1, 16'h0200, 2'b00}));

        // Second edge inside the ISR is held pending
        in_int = 0; cyc();
        in_int = 1; cyc();
        chk("isr_masked", 64'({o_busy, o_freeze, o_mem_req}), 64'(3'b000));
        in_int = 0; rti = 1; cyc();
        rti = 0; rdata = 16'h0005;
        chk("pop_flg", 64'({o_mem_req, o_mem_we, o_mem_addr}), 64'({2'b10, 11'h7FE}));
        cyc();
        chk("pop_flags_load", 64'({o_flags_load, o_flags_value, o_mem_addr}), 64'({1'b1, 4'h5, 11'h7FF}));
        rdata = 16'h1234; cyc();
        chk("pop_pc_load", 64'({o_pc_load, o_pc_value, o_busy}), 64'({1'b1, 16'h1234, 1'b0}));
        pc_ret = 16'h4321; flags = 4'h3; safe = 1; cyc();
        chk("pending_restart", 64'({o_busy, o_freeze, o_flush}), 64'(3'b110));
        cyc(); cyc(); cyc(); cyc();
        chk("second_frame_push", 64'({o_mem_req, o_mem_addr, o_mem_wdata}), 64'({1'b1, 11'h7FF, 16'h4321}));
        cyc();
        chk("second_frame_flg", 64'({o_mem_req, o_mem_addr, o_mem_wdata}), 64'({1'b1, 11'h7FE, 16'h0003}));

        // Asynchronous reset in PUSH_FLG abandons the frame
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outputs", 64'(obs), 64'd0);
        cyc();
        in_int = 0; rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("post_rst_quiet%0d", i), 64'({o_mem_req, o_busy}), 64'(2'b00));
        end
        in_int = 1; cyc();
        cyc(); cyc(); cyc(); cyc();
        chk("post_rst_sp", 64'({o_mem_req, o_mem_addr, o_mem_wdata}), 64'({1'b1, 11'h7FF, 16'h4321}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
